// File: rtl/multi_cycle_control_pkg.sv
// Shared encodings for the multi-cycle RV32I control unit: opcodes, states,
// ALU classes, datapath mux selects and the control-word payload.
package multi_cycle_control_pkg;

  localparam int unsigned OP_W     = 7;
  localparam int unsigned ST_W     = 4;
  localparam int unsigned ALU_OP_W = 3;
  localparam int unsigned SEL_W    = 2;

  localparam logic [OP_W-1:0] OP_R_TYPE = 7'b0110011;
  localparam logic [OP_W-1:0] OP_I_TYPE = 7'b0010011;
  localparam logic [OP_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OP_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OP_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OP_W-1:0] OP_LUI    = 7'b0110111;
  localparam logic [OP_W-1:0] OP_JAL    = 7'b1101111;
  localparam logic [OP_W-1:0] OP_JALR   = 7'b1100111;

  typedef enum logic [ST_W-1:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXEC_R    = 4'd6,
    S_EXEC_I    = 4'd7,
    S_LUI       = 4'd8,
    S_ALU_WB    = 4'd9,
    S_BRANCH    = 4'd10,
    S_JAL       = 4'd11,
    S_JALR      = 4'd12,
    S_TRAP      = 4'd13
  } state_e;

  localparam logic [ALU_OP_W-1:0] ALU_R   = 3'b000;
  localparam logic [ALU_OP_W-1:0] ALU_I   = 3'b001;
  localparam logic [ALU_OP_W-1:0] ALU_BR  = 3'b010;
  localparam logic [ALU_OP_W-1:0] ALU_LUI = 3'b011;
  localparam logic [ALU_OP_W-1:0] ALU_ADD = 3'b100;

  localparam logic [SEL_W-1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [SEL_W-1:0] PC_SRC_ALUOUT = 2'b01;

  localparam logic [SEL_W-1:0] WB_ALUOUT = 2'b00;
  localparam logic [SEL_W-1:0] WB_MDR    = 2'b01;
  localparam logic [SEL_W-1:0] WB_PC     = 2'b10;

  localparam logic [SEL_W-1:0] A_PC     = 2'b00;
  localparam logic [SEL_W-1:0] A_RS1    = 2'b01;
  localparam logic [SEL_W-1:0] A_OLD_PC = 2'b10;
  localparam logic [SEL_W-1:0] A_ZERO   = 2'b11;

  localparam logic [SEL_W-1:0] B_RS2  = 2'b00;
  localparam logic [SEL_W-1:0] B_FOUR = 2'b01;
  localparam logic [SEL_W-1:0] B_IMM  = 2'b10;

  typedef struct packed {
    logic                pc_write;
    logic                pc_write_cond;
    logic [SEL_W-1:0]    pc_src;
    logic                iord;
    logic                mem_read;
    logic                mem_write;
    logic                ir_write;
    logic                reg_write;
    logic [SEL_W-1:0]    mem_to_reg;
    logic [SEL_W-1:0]    alu_src_a;
    logic [SEL_W-1:0]    alu_src_b;
    logic [ALU_OP_W-1:0] alu_op;
    logic                illegal;
  } ctrl_t;

endpackage

// File: rtl/multi_cycle_control_next_state.sv
// Next-state logic of the multi-cycle control FSM.
module multi_cycle_control_next_state
  import multi_cycle_control_pkg::*;
#(
  parameter bit ILLEGAL_HALT = 1'b1
) (
  input  state_e          state_i,
  input  logic [OP_W-1:0] op_i,
  input  logic            mem_ready_i,
  output state_e          next_state_c_o
);

  always_comb begin
    next_state_c_o = S_FETCH;
    case (state_i)
      S_FETCH:     next_state_c_o = mem_ready_i ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op_i)
          OP_R_TYPE:         next_state_c_o = S_EXEC_R;
          OP_I_TYPE:         next_state_c_o = S_EXEC_I;
          OP_LOAD, OP_STORE: next_state_c_o = S_MEM_ADDR;
          OP_BRANCH:         next_state_c_o = S_BRANCH;
          OP_LUI:            next_state_c_o = S_LUI;
          OP_JAL:            next_state_c_o = S_JAL;
          OP_JALR:           next_state_c_o = S_JALR;
          default:           next_state_c_o = S_TRAP;
        endcase
      end
      S_MEM_ADDR:  next_state_c_o = (op_i == OP_LOAD) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  next_state_c_o = mem_ready_i ? S_MEM_WB : S_MEM_READ;
      S_MEM_WRITE: next_state_c_o = mem_ready_i ? S_FETCH : S_MEM_WRITE;
      S_EXEC_R, S_EXEC_I, S_LUI: next_state_c_o = S_ALU_WB;
      S_TRAP:      next_state_c_o = ILLEGAL_HALT ? S_TRAP : S_FETCH;
      // Writeback/PC-update states and undefined encodings all return to fetch.
      default:     next_state_c_o = S_FETCH;
    endcase
  end

endmodule

// File: rtl/multi_cycle_control.sv
// Multi-cycle RV32I control unit: state register plus per-state datapath
// control decode, with a Mealy fetch-complete strobe on Mem_Ready_i.
module multi_cycle_control
  import multi_cycle_control_pkg::*;
#(
  parameter int unsigned ALU_OP_WIDTH = 3,
  parameter int unsigned STATE_WIDTH  = 4,
  parameter bit          ILLEGAL_HALT = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [OP_W-1:0]         OP_i,
  input  logic                    Mem_Ready_i,
  output logic                    PC_Write_o,
  output logic                    PC_Write_Cond_o,
  output logic [1:0]              PC_Src_o,
  output logic                    IorD_o,
  output logic                    Mem_Read_o,
  output logic                    Mem_Write_o,
  output logic                    IR_Write_o,
  output logic                    Reg_Write_o,
  output logic [1:0]              Mem_to_Reg_o,
  output logic [1:0]              ALU_Src_A_o,
  output logic [1:0]              ALU_Src_B_o,
  output logic [ALU_OP_WIDTH-1:0] ALU_Op_o,
  output logic                    Illegal_Op_o,
  output logic [STATE_WIDTH-1:0]  State_o
);

  state_e state_q, state_d;
  ctrl_t  ctl, ctl_c;

  multi_cycle_control_next_state #(
    .ILLEGAL_HALT (ILLEGAL_HALT)
  ) u_next_state (
    .state_i        (state_q),
    .op_i           (OP_i),
    .mem_ready_i    (Mem_Ready_i),
    .next_state_c_o (state_d)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    ctl            = '0;
    ctl.pc_src     = PC_SRC_ALU;
    ctl.mem_to_reg = WB_ALUOUT;
    ctl.alu_src_a  = A_PC;
    ctl.alu_src_b  = B_RS2;
    ctl.alu_op     = ALU_R;
    case (state_q)
      S_FETCH: begin
        ctl.mem_read  = 1'b1;
        ctl.alu_src_b = B_FOUR;
        ctl.alu_op    = ALU_ADD;
        ctl.ir_write  = Mem_Ready_i;
        ctl.pc_write  = Mem_Ready_i;
      end
      S_DECODE: begin
        ctl.alu_src_a = A_OLD_PC;
        ctl.alu_src_b = B_IMM;
        ctl.alu_op    = ALU_ADD;
      end
      S_MEM_ADDR: begin
        ctl.alu_src_a = A_RS1;
        ctl.alu_src_b = B_IMM;
        ctl.alu_op    = ALU_ADD;
      end
      S_MEM_READ: begin
        ctl.iord     = 1'b1;
        ctl.mem_read = 1'b1;
      end
      S_MEM_WB: begin
        ctl.reg_write  = 1'b1;
        ctl.mem_to_reg = WB_MDR;
      end
      S_MEM_WRITE: begin
        ctl.iord      = 1'b1;
        ctl.mem_write = 1'b1;
      end
      S_EXEC_R: begin
        ctl.alu_src_a = A_RS1;
        ctl.alu_op    = ALU_R;
      end
      S_EXEC_I: begin
        ctl.alu_src_a = A_RS1;
        ctl.alu_src_b = B_IMM;
        ctl.alu_op    = ALU_I;
      end
      S_LUI: begin
        ctl.alu_src_a = A_ZERO;
        ctl.alu_src_b = B_IMM;
        ctl.alu_op    = ALU_LUI;
      end
      S_ALU_WB: ctl.reg_write = 1'b1;
      S_BRANCH: begin
        ctl.alu_src_a     = A_RS1;
        ctl.alu_op        = ALU_BR;
        ctl.pc_write_cond = 1'b1;
        ctl.pc_src        = PC_SRC_ALUOUT;
      end
      S_JAL: begin
        ctl.pc_write   = 1'b1;
        ctl.pc_src     = PC_SRC_ALUOUT;
        ctl.reg_write  = 1'b1;
        ctl.mem_to_reg = WB_PC;
      end
      // The A register was latched in DECODE, so rd == rs1 is safe here.
      S_JALR: begin
        ctl.alu_src_a  = A_RS1;
        ctl.alu_src_b  = B_IMM;
        ctl.alu_op     = ALU_ADD;
        ctl.pc_write   = 1'b1;
        ctl.pc_src     = PC_SRC_ALU;
        ctl.reg_write  = 1'b1;
        ctl.mem_to_reg = WB_PC;
      end
      S_TRAP:  ctl.illegal = 1'b1;
      default: ctl.illegal = 1'b0;
    endcase
    ctl_c = reset ? '0 : ctl;
  end

  assign PC_Write_o      = ctl_c.pc_write;
  assign PC_Write_Cond_o = ctl_c.pc_write_cond;
  assign PC_Src_o        = ctl_c.pc_src;
  assign IorD_o          = ctl_c.iord;
  assign Mem_Read_o      = ctl_c.mem_read;
  assign Mem_Write_o     = ctl_c.mem_write;
  assign IR_Write_o      = ctl_c.ir_write;
  assign Reg_Write_o     = ctl_c.reg_write;
  assign Mem_to_Reg_o    = ctl_c.mem_to_reg;
  assign ALU_Src_A_o     = ctl_c.alu_src_a;
  assign ALU_Src_B_o     = ctl_c.alu_src_b;
  assign ALU_Op_o        = ALU_OP_WIDTH'(ctl_c.alu_op);
  assign Illegal_Op_o    = ctl_c.illegal;
  assign State_o         = STATE_WIDTH'(state_q);

endmodule

// File: doc/multi_cycle_control.md
Name: multi_cycle_control

Overview:
- Moore/Mealy FSM control unit for the multi-cycle RISC-V datapath (RV32I subset: R, I-logic, load, store, branch, LUI, JAL, JALR).
- Successor to the single-cycle decoder: sequences each instruction over 3–5 states.
- Supports a variable-latency memory ready handshake and flags illegal opcodes.
- Sits between the instruction register (opcode) and the shared-memory datapath muxes and enables.

Parameters:
ALU_OP_WIDTH, 3, width of ALU_Op_o; codes come from the package.
STATE_WIDTH, 4, width of the state register and State_o.
ILLEGAL_HALT, 1, 1: TRAP state is terminal until reset; 0: TRAP returns to FETCH after one cycle.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
OP_i  input  7  opcode field of the instruction register
Mem_Ready_i  input  1  memory completes the current read/write this cycle
PC_Write_o  output  1  unconditional PC load
PC_Write_Cond_o  output  1  PC load qualified by the datapath branch result
PC_Src_o  output  2  PC source: 00 ALU result, 01 ALUOut register
IorD_o  output  1  memory address: 0 PC, 1 ALUOut
Mem_Read_o  output  1  memory read request
Mem_Write_o  output  1  memory write request
IR_Write_o  output  1  instruction register load
Reg_Write_o  output  1  register file write
Mem_to_Reg_o  output  2  writeback source: 00 ALUOut, 01 MDR, 10 PC
ALU_Src_A_o  output  2  ALU A input: 00 PC, 01 rs1, 10 old PC, 11 zero
ALU_Src_B_o  output  2  ALU B input: 00 rs2, 01 constant 4, 10 immediate
ALU_Op_o  output  ALU_OP_WIDTH  ALU control class: ADD, R, I, BR, LUI
Illegal_Op_o  output  1  unsupported opcode detected
State_o  output  STATE_WIDTH  current state, for debug and verification

Behaviour:
Reset:
- reset=1 forces state=FETCH asynchronously and clears Illegal_Op_o.
- While reset=1, every output is 0 (all enables, mux selects and ALU_Op), except State_o, which shows FETCH.
- A memory transaction in progress is abandoned with no completion cycle.

Default output:
- Any output not listed for a state is 0.

States, outputs and transitions:
- FETCH: IorD=0, Mem_Read=1, A=00, B=01, ALU_Op=ADD.
  - Mem_Ready_i=0: remain in FETCH.
  - Mem_Ready_i=1 (Mealy, same cycle): IR_Write=1, PC_Write=1, PC_Src=00; next state DECODE.
- DECODE: A=10, B=10, ALU_Op=ADD (branch/JAL target into ALUOut). Next state by OP_i:
  - 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - 0000011 or 0100011 -> MEM_ADDR
  - 1100011 -> BRANCH
  - 0110111 -> LUI
  - 1101111 -> JAL
  - 1100111 -> JALR
  - any other -> TRAP
- MEM_ADDR: A=01, B=10, ALU_Op=ADD; next MEM_READ if OP_i=0000011, else MEM_WRITE.
- MEM_READ: IorD=1, Mem_Read=1; hold until Mem_Ready_i=1, then MEM_WB.
- MEM_WB: Reg_Write=1, Mem_to_Reg=01; next FETCH.
- MEM_WRITE: IorD=1, Mem_Write=1, held until Mem_Ready_i=1; then FETCH.
- EXEC_R: A=01, B=00, ALU_Op=R; next ALU_WB.
- EXEC_I: A=01, B=10, ALU_Op=I; next ALU_WB.
- LUI: A=11, B=10, ALU_Op=LUI; next ALU_WB.
- ALU_WB: Reg_Write=1, Mem_to_Reg=00; next FETCH.
- BRANCH: A=01, B=00, ALU_Op=BR, PC_Write_Cond=1, PC_Src=01; next FETCH.
- JAL: PC_Write=1, PC_Src=01, Reg_Write=1, Mem_to_Reg=10 (PC already holds PC+4); next FETCH.
- JALR: A=01, B=10, ALU_Op=ADD, PC_Write=1, PC_Src=00, Reg_Write=1, Mem_to_Reg=10; next FETCH. rd==rs1 is safe because the A register was latched in DECODE.
- TRAP: Illegal_Op_o=1.
  - ILLEGAL_HALT=1: stay in TRAP until reset; Illegal_Op_o stays high.
  - ILLEGAL_HALT=0: one-cycle pulse, then FETCH.

Timing and invariants:
- With Mem_Ready_i tied high, CPI is: R/I/LUI 4, load 5, store 4, branch 3, JAL/JALR 3.
- Each memory wait cycle adds one cycle and holds all outputs stable.
- Mem_Read_o and Mem_Write_o are never high together.
- Reg_Write_o is high for at most one cycle per instruction.
- OP_i is sampled only in DECODE and MEM_ADDR (IR is stable there).
- Undefined state encodings recover to FETCH.

Decomposition:
- Package multi_cycle_control_pkg holds:
  - opcode localparams
  - state encodings
  - ALU_Op codes: R=000, I=001, BR=010, LUI=011, ADD=100
  - mux select codes for PC_Src, Mem_to_Reg, ALU_Src_A, ALU_Src_B
- Sub-module control_next_state: combinational (state, OP_i, Mem_Ready_i) -> next state. The top level holds the state register and output decode.

Test Plan:
- Reset released, Mem_Ready_i=1, OP_i=0110011 -> states FETCH, DECODE, EXEC_R, ALU_WB, FETCH; Reg_Write_o=1 only in cycle 4 with Mem_to_Reg_o=00.
- Load 0000011, Mem_Ready_i low for 3 cycles in MEM_READ -> Mem_Read_o=1 and IorD_o=1 for 4 cycles; MEM_WB Reg_Write_o=1 with Mem_to_Reg_o=01; 8 cycles total.
- Store 0100011, ready delayed 2 cycles -> Mem_Write_o held 3 cycles; Reg_Write_o never 1; Mem_Read_o=0 throughout MEM_WRITE.
- Branch 1100011 -> PC_Write_Cond_o=1 and PC_Src_o=01 in cycle 3; PC_Write_o=0 in that cycle.
- JAL 1101111 -> PC_Write_o=1, Reg_Write_o=1, Mem_to_Reg_o=10 in cycle 3; JALR same with PC_Src_o=00 and ALU_Op_o=100.
- OP_i=1111111 -> TRAP, Illegal_Op_o=1 and sticky (ILLEGAL_HALT=1) with no writes; with ILLEGAL_HALT=0, a one-cycle pulse then FETCH.
- reset asserted mid-MEM_WRITE -> Mem_Write_o drops the same cycle (asynchronous) and State_o=FETCH.
